// File: rtl/core_dmem_bridge.sv
// Data-memory bridge between the rv32e load/store port and a req/ack memory.
// Handles one access at a time: lane steering, load extension, alignment and ack timeout.
module core_dmem_bridge #(
    parameter int          MEMORY_WIDTH = 32,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] ADDRESS      = 32'h0000_0000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req_i,
    input  logic [31:0]             addr_i,
    input  logic [MEMORY_WIDTH-1:0] data_i,
    input  logic                    data_w_i,
    input  logic [2:0]              data_mode_i,
    output logic [MEMORY_WIDTH-1:0] data_o,
    output logic                    stall_o,
    output logic                    err_o,
    output logic                    mem_req_o,
    output logic [31:0]             mem_addr_o,
    output logic [MEMORY_WIDTH-1:0] mem_data_o,
    output logic [3:0]              mem_be_o,
    output logic                    mem_we_o,
    input  logic                    mem_ack_i,
    input  logic [MEMORY_WIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] lane);
        case (mode)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] mode, input logic [1:0] lane);
        case (mode)
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] mode, input logic [31:0] data);
        case (mode)
            2'b00:   store_data = {4{data[7:0]}};
            2'b01:   store_data = {2{data[15:0]}};
            default: store_data = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] mode, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (mode[1:0])
            2'b00:   load_extract = mode[2] ? {24'h00_0000, b} : {{24{b[7]}}, b};
            2'b01:   load_extract = mode[2] ? {16'h0000, h} : {{16{h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    state_t      state_r;
    state_t      next_s;
    logic [1:0]  lane_r;
    logic [2:0]  mode_r;
    logic        we_r;
    logic [15:0] cnt_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_data_r;
    logic [3:0]  mem_be_r;
    logic        mem_we_r;
    logic        mem_req_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic [31:0] addr_off_s;

    assign addr_off_s = addr_i - ADDRESS;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; the timeout fires on the WAIT cycle whose count reaches TIMEOUT
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    next_s = misaligned(data_mode_i[1:0], addr_i[1:0]) ? ST_ERR : ST_WAIT;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    next_s = ST_RESP;
                end else if ((cnt_r + 16'd1) == TIMEOUT_C) begin
                    next_s = ST_ERR;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_RESP: next_s = ST_IDLE;
            ST_ERR:  next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Access capture, memory-side drive and the one-cycle load result / error pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lane_r     <= 2'b00;
            mode_r     <= 3'b000;
            we_r       <= 1'b0;
            cnt_r      <= 16'd0;
            mem_addr_r <= 32'h0000_0000;
            mem_data_r <= 32'h0000_0000;
            mem_be_r   <= 4'b0000;
            mem_we_r   <= 1'b0;
            mem_req_r  <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
        end else begin
            err_r     <= (next_s == ST_ERR);
            mem_req_r <= (next_s == ST_WAIT);
            rdata_r   <= 32'h0000_0000;
            case (state_r)
                ST_IDLE: begin
                    if (cpu_req_i) begin
                        lane_r <= addr_i[1:0];
                        mode_r <= data_mode_i;
                        we_r   <= data_w_i;
                        cnt_r  <= 16'd0;
                        // Misaligned accesses never touch the memory-side outputs
                        if (next_s == ST_WAIT) begin
                            mem_addr_r <= {addr_off_s[31:2], 2'b00};
                            mem_data_r <= data_w_i ? store_data(data_mode_i[1:0], data_i) : 32'h0000_0000;
                            mem_be_r   <= data_w_i ? store_be(data_mode_i[1:0], addr_i[1:0]) : 4'b1111;
                            mem_we_r   <= data_w_i;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (mem_ack_i && !we_r) begin
                        rdata_r <= load_extract(mode_r, lane_r, mem_data_i);
                    end
                    if (next_s != ST_WAIT) begin
                        mem_addr_r <= 32'h0000_0000;
                        mem_data_r <= 32'h0000_0000;
                        mem_be_r   <= 4'b0000;
                        mem_we_r   <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= 16'd0;
                end
            endcase
        end
    end

    // Stall is the only combinational output: IDLE must hold the core in the request cycle
    assign stall_o    = reset & ((state_r == ST_WAIT) | ((state_r == ST_IDLE) & cpu_req_i));
    assign data_o     = rdata_r;
    assign err_o      = err_r;
    assign mem_req_o  = mem_req_r;
    assign mem_addr_o = mem_addr_r;
    assign mem_data_o = mem_data_r;
    assign mem_be_o   = mem_be_r;
    assign mem_we_o   = mem_we_r;

endmodule
